// File: rtl/channel_arbiter_array_if.sv
// rtl/channel_arbiter_array_if.sv - per-channel ingress and merged egress handshake bundle
interface channel_arbiter_array_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2
);
    logic [CHANNELS-1:0]                    i_valid;
    logic [CHANNELS-1:0]                    o_ready;
    logic [CHANNELS*WIDTH-1:0]              i_data;
    logic                                   o_valid;
    logic                                   i_ready;
    logic [WIDTH-1:0]                       o_data;
    logic [$clog2(CHANNELS)-1:0]            o_chan;
    logic [CHANNELS*$clog2(DEPTH+1)-1:0]    o_count;

    // Producer/consumer side drives the inputs and observes the merged output.
    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_chan, o_count
    );

    // Arbiter side.
    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_chan, o_count
    );
endinterface

// File: rtl/channel_arbiter_array.sv
// rtl/channel_arbiter_array.sv - per-channel FIFOs merged onto one registered output by arbitration
module channel_arbiter_array #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    channel_arbiter_array_if.slave  bus
);
    localparam int CHW = $clog2(CHANNELS);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [CHW-1:0] LAST_CHAN = CHW'(CHANNELS - 1);

    logic [WIDTH-1:0]    mem_q   [CHANNELS][DEPTH];
    logic [AW-1:0]       rptr_q  [CHANNELS];
    logic [AW-1:0]       wptr_q  [CHANNELS];
    logic [CW-1:0]       count_q [CHANNELS];
    logic [CW-1:0]       count_d [CHANNELS];

    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    logic [CHW-1:0]      ptr_q, ptr_d;
    logic [CHW-1:0]      cand;
    logic [CHW-1:0]      win_idx;
    logic                win_found;
    logic                load;

    logic                o_valid_q, o_valid_d;
    logic [WIDTH-1:0]    o_data_q,  o_data_d;
    logic [CHW-1:0]      o_chan_q,  o_chan_d;

    // The output register refills when it is empty or being drained this cycle.
    assign load = !o_valid_q || bus.i_ready;

    // Channel status from registered occupancy; ready is held low throughout reset.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            nonempty[c] = (count_q[c] != '0);
            ready[c]    = !i_rst && (count_q[c] != FULL_CNT);
        end
    end

    // Pick the winner: rotate from ptr+1 in round-robin, else lowest index first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ARB_MODE == 1) begin
                cand = CHW'(k);
            end else begin
                cand = CHW'((int'(ptr_q) + 1 + k) % CHANNELS);
            end
            if (!win_found && nonempty[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Per-channel push/pop strobes and next occupancy.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            push[c]    = bus.i_valid[c] && ready[c];
            pop[c]     = load && win_found && (win_idx == CHW'(c));
            count_d[c] = count_q[c] + CW'(push[c]) - CW'(pop[c]);
        end
    end

    // Next output register contents and arbitration pointer.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_chan_d  = o_chan_q;
        ptr_d     = ptr_q;
        if (load) begin
            o_valid_d = win_found;
            if (win_found) begin
                o_data_d = mem_q[win_idx][rptr_q[win_idx]];
                o_chan_d = win_idx;
                if (ARB_MODE == 0) begin
                    ptr_d = win_idx;
                end
            end
        end
    end

    // Control state: occupancy, FIFO pointers, output register, grant pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= '0;
                rptr_q[c]  <= '0;
                wptr_q[c]  <= '0;
            end
            ptr_q     <= LAST_CHAN;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_chan_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c] <= count_d[c];
                if (push[c]) begin
                    wptr_q[c] <= wptr_q[c] + 1'b1;
                end
                if (pop[c]) begin
                    rptr_q[c] <= rptr_q[c] + 1'b1;
                end
            end
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_chan_q  <= o_chan_d;
        end
    end

    // FIFO storage writes; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= bus.i_data[c*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_chan  = o_chan_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign bus.o_count[g*CW +: CW] = count_q[g];
    end
endmodule

// File: tb/tb_channel_arbiter_array.sv
// tb/tb_channel_arbiter_array.sv - round-robin and fixed-priority arbiters against a queue model
module tb_channel_arbiter_array;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int D  = 2;

    logic        clk;
    logic        i_rst;
    logic [3:0]  i_valid;
    logic [31:0] i_data;
    logic        i_ready;
    logic        chk_en;

    int n_err;
    int n_checks;

    // Model state: index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [7:0] mq [8][$];
    int         mv [2];
    int         md [2];
    int         mc [2];
    int         mp [2];

    channel_arbiter_array_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) if_rr ();
    channel_arbiter_array_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) if_fp ();

    assign if_rr.i_valid = i_valid;
    assign if_rr.i_data  = i_data;
    assign if_rr.i_ready = i_ready;
    assign if_fp.i_valid = i_valid;
    assign if_fp.i_data  = i_data;
    assign if_fp.i_ready = i_ready;

    channel_arbiter_array #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .ARB_MODE(0)) dut_rr (
        .i_clk (clk),
        .i_rst (i_rst),
        .bus   (if_rr.slave)
    );

    channel_arbiter_array #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .ARB_MODE(1)) dut_fp (
        .i_clk (clk),
        .i_rst (i_rst),
        .bus   (if_fp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit2(input string name, input logic [31:0] a_rr, input logic [31:0] a_fp,
                        input logic [31:0] exp);
        chk({"rr_", name}, a_rr, exp);
        chk({"fp_", name}, a_fp, exp);
    endtask

    // One clock edge of the specification, applied to queues.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (i_rst) begin
                for (int c = 0; c < CH; c++) mq[m*CH+c].delete();
                mv[m] = 0;
                md[m] = 0;
                mc[m] = 0;
                mp[m] = CH - 1;
            end else begin
                bit acc [CH];
                int w;
                for (int c = 0; c < CH; c++)
                    acc[c] = i_valid[c] && (mq[m*CH+c].size() < D);
                if (mv[m] == 0 || i_ready) begin
                    w = -1;
                    for (int k = 0; k < CH; k++) begin
                        int cnd;
                        cnd = (m == 0) ? (mp[m] + 1 + k) % CH : k;
                        if (w < 0 && mq[m*CH+cnd].size() > 0) w = cnd;
                    end
                    if (w >= 0) begin
                        md[m] = mq[m*CH+w].pop_front();
                        mc[m] = w;
                        mv[m] = 1;
                        if (m == 0) mp[m] = w;
                    end else begin
                        mv[m] = 0;
                    end
                end
                for (int c = 0; c < CH; c++)
                    if (acc[c]) mq[m*CH+c].push_back(i_data[c*8 +: 8]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic cmp_dut(input int m, input logic [3:0] rdy, input logic vld,
                           input logic [7:0] dat, input logic [1:0] chn, input logic [7:0] cnt);
        logic [3:0] e_rdy;
        logic [7:0] e_cnt;
        string      p;
        p = (m == 0) ? "rr" : "fp";
        for (int c = 0; c < CH; c++) begin
            e_rdy[c]         = !i_rst && (mq[m*CH+c].size() < D);
            e_cnt[c*2 +: 2]  = 2'(mq[m*CH+c].size());
        end
        chk($sformatf("%s_ready", p), 32'(rdy), 32'(e_rdy));
        chk($sformatf("%s_valid", p), 32'(vld), 32'(mv[m]));
        chk($sformatf("%s_count", p), 32'(cnt), 32'(e_cnt));
        if (mv[m] != 0) begin
            chk($sformatf("%s_data", p), 32'(dat), 32'(md[m]));
            chk($sformatf("%s_chan", p), 32'(chn), 32'(mc[m]));
        end
    endtask

    // Every cycle, both instances must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, if_rr.o_ready, if_rr.o_valid, if_rr.o_data, if_rr.o_chan, if_rr.o_count);
            cmp_dut(1, if_fp.o_ready, if_fp.o_valid, if_fp.o_data, if_fp.o_chan, if_fp.o_count);
        end
    end

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 4'h0;
        tick();
        i_rst   = 1'b0;
    endtask

    task automatic preload();
        i_ready = 1'b0;
        i_valid = 4'hF;
        i_data  = 32'h30201000;
        tick();
        i_data  = 32'h31211101;
        tick();
        i_valid = 4'h0;
    endtask

    logic [7:0] rr_seq [8];
    logic [7:0] fp_seq [8];

    initial begin
        n_err    = 0;
        n_checks = 0;
        chk_en   = 1'b0;
        i_rst    = 1'b1;
        i_valid  = 4'hF;
        i_data   = 32'h5A5A5A5A;
        i_ready  = 1'b0;
        rr_seq   = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
        fp_seq   = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};

        // Reset held three cycles with every producer asserting valid.
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        lit2("rst_ready", if_rr.o_ready, if_fp.o_ready, 32'h0);
        lit2("rst_valid", if_rr.o_valid, if_fp.o_valid, 32'h0);
        lit2("rst_count", if_rr.o_count, if_fp.o_count, 32'h0);
        lit2("rst_data",  if_rr.o_data,  if_fp.o_data,  32'h0);
        lit2("rst_chan",  if_rr.o_chan,  if_fp.o_chan,  32'h0);
        i_rst   = 1'b0;
        i_valid = 4'h0;
        #1;
        lit2("post_rst_ready", if_rr.o_ready, if_fp.o_ready, 32'hF);

        // Single beat on channel 2.
        i_ready = 1'b1;
        i_valid = 4'b0100;
        i_data  = 32'h00A50000;
        tick();
        i_valid = 4'h0;
        lit2("single_lat", if_rr.o_valid, if_fp.o_valid, 32'h0);
        tick();
        lit2("single_valid", if_rr.o_valid, if_fp.o_valid, 32'h1);
        lit2("single_data",  if_rr.o_data,  if_fp.o_data,  32'hA5);
        lit2("single_chan",  if_rr.o_chan,  if_fp.o_chan,  32'h2);
        tick();
        lit2("single_drain", if_rr.o_valid, if_fp.o_valid, 32'h0);

        // All channels preloaded with two beats, then drained back-to-back.
        do_reset();
        preload();
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_seq_valid%0d", i), 32'(if_rr.o_valid), 32'h1);
            chk($sformatf("rr_seq_data%0d", i),  32'(if_rr.o_data),  32'(rr_seq[i]));
            chk($sformatf("rr_seq_chan%0d", i),  32'(if_rr.o_chan),  32'(rr_seq[i][5:4]));
            chk($sformatf("fp_seq_valid%0d", i), 32'(if_fp.o_valid), 32'h1);
            chk($sformatf("fp_seq_data%0d", i),  32'(if_fp.o_data),  32'(fp_seq[i]));
            chk($sformatf("fp_seq_chan%0d", i),  32'(if_fp.o_chan),  32'(fp_seq[i][5:4]));
            tick();
        end
        lit2("seq_end_valid", if_rr.o_valid, if_fp.o_valid, 32'h0);

        // Backpressure: three beats on channel 1 fill output register and FIFO.
        do_reset();
        i_ready = 1'b0;
        i_valid = 4'b0010;
        i_data  = 32'h00004100;
        tick();
        i_data  = 32'h00004200;
        tick();
        i_data  = 32'h00004300;
        tick();
        i_data  = 32'h00004400;
        lit2("bp_ready1", if_rr.o_ready[1], if_fp.o_ready[1], 32'h0);
        lit2("bp_count",  if_rr.o_count,    if_fp.o_count,    32'h08);
        lit2("bp_data",   if_rr.o_data,     if_fp.o_data,     32'h41);
        lit2("bp_chan",   if_rr.o_chan,     if_fp.o_chan,     32'h1);
        tick();
        lit2("bp_hold_data",  if_rr.o_data,  if_fp.o_data,  32'h41);
        lit2("bp_hold_count", if_rr.o_count, if_fp.o_count, 32'h08);
        i_ready = 1'b1;
        tick();
        lit2("rel_data0",  if_rr.o_data,     if_fp.o_data,     32'h42);
        lit2("rel_ready1", if_rr.o_ready[1], if_fp.o_ready[1], 32'h1);
        lit2("rel_count0", if_rr.o_count,    if_fp.o_count,    32'h04);
        tick();
        i_valid = 4'h0;
        lit2("rel_data1",  if_rr.o_data,  if_fp.o_data,  32'h43);
        lit2("rel_count1", if_rr.o_count, if_fp.o_count, 32'h04);
        tick();
        lit2("rel_data2",  if_rr.o_data,  if_fp.o_data,  32'h44);
        lit2("rel_count2", if_rr.o_count, if_fp.o_count, 32'h00);
        tick();
        lit2("rel_end_valid", if_rr.o_valid, if_fp.o_valid, 32'h0);

        // Reset while a burst is in flight.
        do_reset();
        preload();
        i_ready = 1'b1;
        tick();
        lit2("mid_pre_valid", if_rr.o_valid, if_fp.o_valid, 32'h1);
        i_rst = 1'b1;
        tick();
        lit2("mid_valid", if_rr.o_valid, if_fp.o_valid, 32'h0);
        lit2("mid_count", if_rr.o_count, if_fp.o_count, 32'h0);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit2($sformatf("mid_stale%0d", i), if_rr.o_valid, if_fp.o_valid, 32'h0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
